// File: rtl/instr_fetch.sv
// Fetch stage of the accumulator CPU: owns the PC, requests words from program
// memory, holds them in the IR and offers them to the decoder until accepted.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 8
`endif

module instr_fetch #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = `INSTRUCTION_WIDTH,
    parameter int LAST_ADDR   = 2**PC_WIDTH-1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   id_ready,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   done,
    output logic [1:0]             fsm_state
);

    // Handshakes: a memory read completes on a rising edge where imem_req and
    // imem_ack are both high; an instruction transfers to the decoder on a
    // rising edge where instr_valid and id_ready are both high. Neither
    // imem_req nor instr_valid ever depends combinationally on ack/ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(LAST_ADDR);

    state_t                 state_q;
    state_t                 state_d;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic                   last_q;
    logic                   capture;

    assign capture = (state_q == FETCH) && imem_ack;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) state_d = HOLD;
            end
            HOLD: begin
                // last_q, not the wrapped pc, decides end of program
                if (id_ready) begin
                    if (last_q)   state_d = DONE;
                    else if (run) state_d = FETCH;
                    else          state_d = IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                ir_q   <= imem_data;
                pc_q   <= pc_q + PC_WIDTH'(1);
                last_q <= (pc_q == LAST_PC);
            end
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = ir_q;
    assign instr_valid = (state_q == HOLD);
    assign pc          = pc_q;
    assign done        = (state_q == DONE);
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one instance with a 4-bit PC ending at
// address 3, and one with a 2-bit PC to exercise the wrap to zero.
module tb_instr_fetch;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, run_a, req_a, ack_a, valid_a, ready_a, done_a;
    logic [3:0] addr_a, pc_a;
    logic [7:0] data_a, instr_a;
    logic [1:0] st_a;

    logic       rst_b, run_b, req_b, ack_b, valid_b, ready_b, done_b;
    logic [1:0] addr_b, pc_b;
    logic [7:0] data_b, instr_b;
    logic [1:0] st_b;

    instr_fetch #(.PC_WIDTH(4), .INSTR_WIDTH(8), .LAST_ADDR(3)) dut_a (
        .clk(clk), .rst(rst_a), .run(run_a),
        .imem_req(req_a), .imem_addr(addr_a), .imem_ack(ack_a), .imem_data(data_a),
        .instr(instr_a), .instr_valid(valid_a), .id_ready(ready_a),
        .pc(pc_a), .done(done_a), .fsm_state(st_a)
    );

    instr_fetch #(.PC_WIDTH(2), .INSTR_WIDTH(8), .LAST_ADDR(3)) dut_b (
        .clk(clk), .rst(rst_b), .run(run_b),
        .imem_req(req_b), .imem_addr(addr_b), .imem_ack(ack_b), .imem_data(data_b),
        .instr(instr_b), .instr_valid(valid_b), .id_ready(ready_b),
        .pc(pc_b), .done(done_b), .fsm_state(st_b)
    );

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [4];
    logic [7:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_xfer;
        int extra_req;
        int addr0_req;
        logic [7:0] exp;

        rst_a = 1'b1; run_a = 1'b0; ack_a = 1'b0; data_a = '0; ready_a = 1'b0;
        rst_b = 1'b1; run_b = 1'b0; ack_b = 1'b0; data_b = '0; ready_b = 1'b0;
        for (int i = 0; i < 16; i++) mem_a[i] = 8'h00;
        mem_a[0] = 8'h3A; mem_a[1] = 8'h5C; mem_a[2] = 8'h77; mem_a[3] = 8'h5C;
        tick; tick;
        rst_a = 1'b0;

        // reset values
        check("rst_state", st_a, S_IDLE);
        check("rst_pc", pc_a, 0);
        check("rst_req", req_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_done", done_a, 0);
        check("rst_instr", instr_a, 0);
        tick; tick;
        check("idle_no_req", req_a, 0);

        // basic fetch: ack in the second FETCH cycle
        run_a = 1'b1; ready_a = 1'b1;
        tick;
        check("bf_req", req_a, 1);
        check("bf_addr", addr_a, 0);
        check("bf_state", st_a, S_FETCH);
        tick;
        check("bf_req_hold", req_a, 1);
        check("bf_valid_early", valid_a, 0);
        ack_a = 1'b1; data_a = mem_a[addr_a];
        tick;
        ack_a = 1'b0; data_a = '0;
        check("bf_valid", valid_a, 1);
        check("bf_instr", instr_a, 8'h3A);
        check("bf_pc", pc_a, 1);
        check("bf_req_low", req_a, 0);
        tick;
        check("bf_valid_after", valid_a, 0);
        check("bf_next_req", req_a, 1);
        check("bf_next_addr", addr_a, 1);

        // back-pressure with a stray ack during HOLD
        ready_a = 1'b0; ack_a = 1'b1; data_a = mem_a[addr_a];
        tick;
        ack_a = 1'b0; data_a = '0;
        check("bp_instr0", instr_a, 8'h5C);
        check("bp_pc0", pc_a, 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ack_a = 1'b1; data_a = 8'hEE;
            end
            tick;
            ack_a = 1'b0; data_a = '0;
            check("bp_valid", valid_a, 1);
            check("bp_instr", instr_a, 8'h5C);
            check("bp_req", req_a, 0);
            check("bp_pc", pc_a, 2);
        end
        ready_a = 1'b1; run_a = 1'b0;
        tick;
        ready_a = 1'b0;
        check("bp_xfer_valid", valid_a, 0);
        check("bp_xfer_state", st_a, S_IDLE);
        check("bp_xfer_req", req_a, 0);
        tick;
        check("bp_idle_state", st_a, S_IDLE);
        check("bp_idle_pc", pc_a, 2);

        // slow memory, run dropped mid-wait
        run_a = 1'b1;
        tick;
        check("sm_req0", req_a, 1);
        check("sm_addr0", addr_a, 2);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) run_a = 1'b0;
            tick;
            check("sm_req", req_a, 1);
            check("sm_addr", addr_a, 2);
            check("sm_valid", valid_a, 0);
        end
        ack_a = 1'b1; data_a = mem_a[addr_a];
        tick;
        ack_a = 1'b0; data_a = '0;
        check("sm_instr", instr_a, 8'h77);
        check("sm_valid_cap", valid_a, 1);
        check("sm_pc", pc_a, 3);
        ready_a = 1'b1;
        tick;
        ready_a = 1'b0;
        check("sm_idle", st_a, S_IDLE);
        check("sm_done", done_a, 0);

        // async reset mid-FETCH with a simultaneous ack
        run_a = 1'b1;
        tick;
        check("ra_state", st_a, S_FETCH);
        check("ra_addr", addr_a, 3);
        rst_a = 1'b1; ack_a = 1'b1; data_a = 8'h99;
        #1;
        check("ra_pc", pc_a, 0);
        check("ra_instr", instr_a, 0);
        check("ra_req", req_a, 0);
        check("ra_valid", valid_a, 0);
        check("ra_done", done_a, 0);
        check("ra_state_idle", st_a, S_IDLE);
        tick;
        check("ra_instr_held", instr_a, 0);
        check("ra_pc_held", pc_a, 0);
        rst_a = 1'b0; ack_a = 1'b0; data_a = '0; run_a = 1'b0;
        tick;

        // program end at LAST_ADDR=3
        mem_a[0] = 8'h11; mem_a[1] = 8'h22; mem_a[2] = 8'h33; mem_a[3] = 8'h44;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        n_xfer = 0;
        run_a = 1'b1; ready_a = 1'b1;
        for (int cyc = 0; cyc < 40 && !done_a; cyc++) begin
            ack_a  = req_a;
            data_a = req_a ? mem_a[addr_a] : 8'h00;
            if (valid_a) begin
                if (exp_q.size() == 0) begin
                    check("pe_extra_xfer", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    check("pe_instr", instr_a, exp);
                    check("pe_pc", pc_a, n_xfer + 1);
                end
                n_xfer++;
            end
            tick;
        end
        ack_a = 1'b0; data_a = '0;
        check("pe_done", done_a, 1);
        check("pe_xfers", n_xfer, 4);
        check("pe_queue_left", exp_q.size(), 0);
        check("pe_pc_final", pc_a, 4);
        extra_req = 0;
        for (int i = 0; i < 4; i++) begin
            run_a = i[0];
            tick;
            if (req_a) extra_req++;
        end
        check("pe_no_req", extra_req, 0);
        check("pe_done_sticky", done_a, 1);
        check("pe_valid_low", valid_a, 0);

        // wrap: 2-bit PC, last_q must end the program
        mem_b[0] = 8'hA1; mem_b[1] = 8'hB2; mem_b[2] = 8'hC3; mem_b[3] = 8'hD4;
        exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        n_xfer = 0;
        addr0_req = 0;
        rst_b = 1'b0; run_b = 1'b1; ready_b = 1'b1;
        for (int cyc = 0; cyc < 40 && !done_b; cyc++) begin
            if (req_b && addr_b == 2'd0) addr0_req++;
            ack_b  = req_b;
            data_b = req_b ? mem_b[addr_b] : 8'h00;
            if (valid_b) begin
                if (exp_q.size() == 0) begin
                    check("wr_extra_xfer", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    check("wr_instr", instr_b, exp);
                    check("wr_pc", pc_b, (n_xfer + 1) % 4);
                end
                n_xfer++;
            end
            tick;
        end
        ack_b = 1'b0; data_b = '0;
        check("wr_done", done_b, 1);
        check("wr_state", st_b, S_DONE);
        check("wr_pc_final", pc_b, 0);
        check("wr_xfers", n_xfer, 4);
        for (int i = 0; i < 4; i++) begin
            tick;
            if (req_b && addr_b == 2'd0) addr0_req++;
        end
        check("wr_addr0_once", addr0_req, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
